// File: rtl/pll_reset_seq.sv
// PLL power-up / lock-supervision reset sequencer on the reference clock.
// Define PLL_RST_SEQ_LOSTCNT_EN to build the saturating lock-loss counter.
module pll_reset_seq #(
  parameter int LOCK_WAIT      = 5000,
  parameter int PLL_RST_CYCLES = 32,
  parameter int LOCK_TIMEOUT   = 500000,
  parameter int MAX_RETRY      = 7
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       soft_reset,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [2:0] retry_cnt,
  output logic [7:0] lost_cnt
);

  localparam int MAX_A = (LOCK_TIMEOUT > LOCK_WAIT) ?
                         LOCK_TIMEOUT : LOCK_WAIT;
  localparam int MAX_V = (MAX_A > PLL_RST_CYCLES) ?
                         MAX_A : PLL_RST_CYCLES;
  localparam int CW    = (MAX_V > 1) ? $clog2(MAX_V) : 1;

  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_RST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] C_TO   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] C_WAIT = CW'(LOCK_WAIT - 1);
  localparam logic [2:0]    C_MAXR = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_PLLRST,
    S_WAITLOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t          r_state;
  state_t          w_nstate;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_ncnt;
  logic [2:0]      r_retry;
  logic [2:0]      w_nretry;
  logic [2:0]      w_retry_inc;
  logic            w_nlost;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_pll_rst;
  logic            r_sys_reset;
  logic            r_ready;
  logic            r_fail;
  logic            r_lock_lost;

  assign w_retry_inc = r_retry + 3'd1;

  // Two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= locked;
      r_sync2 <= r_sync1;
    end
  end

  // Next state, shared timer and retry count; soft_reset overrides all
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt + C_ONE;
    w_nretry = r_retry;
    w_nlost  = 1'b0;
    if (soft_reset) begin
      w_nstate = S_PLLRST;
      w_ncnt   = '0;
      w_nretry = '0;
    end else begin
      unique case (r_state)
        S_PLLRST: begin
          if (r_cnt == C_RST) begin
            w_nstate = S_WAITLOCK;
            w_ncnt   = '0;
          end
        end
        S_WAITLOCK: begin
          if (r_sync2) begin
            w_nstate = S_STABLE;
            w_ncnt   = '0;
          end else if (r_cnt == C_TO) begin
            w_nretry = w_retry_inc;
            w_ncnt   = '0;
            w_nstate = (w_retry_inc == C_MAXR) ?
                       S_FAIL : S_PLLRST;
          end
        end
        S_STABLE: begin
          if (!r_sync2) begin
            w_nstate = S_WAITLOCK;
            w_ncnt   = '0;
          end else if (r_cnt == C_WAIT) begin
            w_nstate = S_RUN;
            w_ncnt   = '0;
            w_nretry = '0;
          end
        end
        S_RUN: begin
          w_ncnt = '0;
          if (!r_sync2) begin
            w_nstate = S_PLLRST;
            w_nlost  = 1'b1;
          end
        end
        S_FAIL: begin
          w_ncnt = '0;
        end
        default: begin
          w_nstate = S_PLLRST;
          w_ncnt   = '0;
        end
      endcase
    end
  end

  // State, timer and registered outputs decoded from the next state
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_PLLRST;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_reset <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_nstate;
      r_cnt       <= w_ncnt;
      r_retry     <= w_nretry;
      r_pll_rst   <= (w_nstate == S_PLLRST);
      r_sys_reset <= (w_nstate != S_RUN);
      r_ready     <= (w_nstate == S_RUN);
      r_fail      <= (w_nstate == S_FAIL);
      r_lock_lost <= w_nlost;
    end
  end

`ifdef PLL_RST_SEQ_LOSTCNT_EN
  logic [7:0] r_lost_cnt;

  // Saturating count of lock losses seen while running
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_lost_cnt <= '0;
    end else if (w_nlost && (r_lost_cnt != 8'hFF)) begin
      r_lost_cnt <= r_lost_cnt + 8'd1;
    end
  end

  assign lost_cnt = r_lost_cnt;
`else
  assign lost_cnt = 8'd0;
`endif

  assign pll_rst   = r_pll_rst;
  assign sys_reset = r_sys_reset;
  assign ready     = r_ready;
  assign fail      = r_fail;
  assign lock_lost = r_lock_lost;
  assign retry_cnt = r_retry;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: expected output changes are queued
// with their edge number; a negedge monitor pops and compares on change.
module tb_pll_reset_seq;

  logic       refclk;
  logic       rst_n;
  logic       locked;
  logic       soft_reset;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [2:0] retry_cnt;
  logic [7:0] lost_cnt;

  pll_reset_seq #(
    .LOCK_WAIT     (8),
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (20),
    .MAX_RETRY     (3)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .locked    (locked),
    .soft_reset(soft_reset),
    .pll_rst   (pll_rst),
    .sys_reset (sys_reset),
    .ready     (ready),
    .fail      (fail),
    .lock_lost (lock_lost),
    .retry_cnt (retry_cnt),
    .lost_cnt  (lost_cnt)
  );

`ifdef PLL_RST_SEQ_LOSTCNT_EN
  localparam int NLOSS = 300;
`else
  localparam int NLOSS = 3;
`endif

  typedef struct {
    int          cyc;
    logic [15:0] v;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          exp_lost = 0;
  logic [15:0] prev = 'x;

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  always @(posedge refclk) cyc <= cyc + 1;

  function automatic logic [15:0] vec(bit p, bit s, bit r, bit f,
                                      bit l, int rc, int lc);
    return {p, s, r, f, l, 3'(rc), 8'(lc)};
  endfunction

  task automatic push(int c, logic [15:0] v, string tag);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic to_cyc(int c);
    while (cyc != c) begin
      @(posedge refclk);
      #1;
    end
  endtask

  // Monitor: every output change must match the next queued expectation
  always @(negedge refclk) begin
    logic [15:0] v;
    exp_t        e;
    v = {pll_rst, sys_reset, ready, fail, lock_lost, retry_cnt, lost_cnt};
    if (v !== prev) begin
      prev = v;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change cyc=%0d got=%h", cyc, v);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.v !== v) begin
          failures++;
          $display("FAIL %s got cyc=%0d vec=%h want cyc=%0d vec=%h",
                   e.tag, cyc, v, e.cyc, e.v);
        end
      end
    end
  end

  task automatic bump_lost();
`ifdef PLL_RST_SEQ_LOSTCNT_EN
    if (exp_lost < 255) exp_lost++;
`endif
  endtask

  // Drop lock in RUN; returns once the FSM is back in WAITLOCK
  task automatic lose_base();
    int c;
    c = cyc;
    locked = 1'b0;
    bump_lost();
    push(c + 3, vec(1, 1, 0, 0, 1, 0, exp_lost), "lost_pulse");
    push(c + 4, vec(1, 1, 0, 0, 0, 0, exp_lost), "lost_end");
    push(c + 7, vec(0, 1, 0, 0, 0, 0, exp_lost), "lost_waitlock");
    to_cyc(c + 7);
  endtask

  task automatic lose_relock();
    int d;
    lose_base();
    d = cyc;
    locked = 1'b1;
    push(d + 11, vec(0, 0, 1, 0, 0, 0, exp_lost), "relock_ready");
    to_cyc(d + 13);
  endtask

  initial begin
    int r;
    int d;
    int s;
    int w;
    int f;
    rst_n      = 1'b1;
    locked     = 1'b0;
    soft_reset = 1'b0;
    #1;
    rst_n = 1'b0;
    push(1, vec(1, 1, 0, 0, 0, 0, 0), "reset_state");
    to_cyc(3);

    rst_n = 1'b1;
    r = cyc;
    push(r + 4, vec(0, 1, 0, 0, 0, 0, 0), "powerup_pllrst_len");
    to_cyc(r + 7);
    d = cyc;
    locked = 1'b1;
    push(d + 11, vec(0, 0, 1, 0, 0, 0, 0), "powerup_ready");
    to_cyc(d + 13);

    for (int i = 0; i < NLOSS; i++) lose_relock();

    lose_base();
    d = cyc;
    locked = 1'b1;
    to_cyc(d + 5);
    locked = 1'b0;
    to_cyc(d + 6);
    locked = 1'b1;
    push(d + 17, vec(0, 0, 1, 0, 0, 0, exp_lost), "chatter_ready");
    to_cyc(d + 19);

    s = cyc;
    soft_reset = 1'b1;
    push(s + 1, vec(1, 1, 0, 0, 0, 0, exp_lost), "soft_run");
    to_cyc(s + 3);
    soft_reset = 1'b0;
    push(s + 7, vec(0, 1, 0, 0, 0, 0, exp_lost), "soft_hold_len");
    push(s + 16, vec(0, 0, 1, 0, 0, 0, exp_lost), "soft_ready");
    to_cyc(s + 18);

    lose_base();
    w = cyc;
    push(w + 20, vec(1, 1, 0, 0, 0, 1, exp_lost), "timeout1");
    push(w + 24, vec(0, 1, 0, 0, 0, 1, exp_lost), "pulse1_end");
    push(w + 44, vec(1, 1, 0, 0, 0, 2, exp_lost), "timeout2");
    push(w + 48, vec(0, 1, 0, 0, 0, 2, exp_lost), "pulse2_end");
    push(w + 68, vec(0, 1, 0, 1, 0, 3, exp_lost), "enter_fail");
    to_cyc(w + 75);

    f = cyc;
    locked = 1'b1;
    soft_reset = 1'b1;
    push(f + 1, vec(1, 1, 0, 0, 0, 0, exp_lost), "recover_clear");
    push(f + 5, vec(0, 1, 0, 0, 0, 0, exp_lost), "recover_pllrst");
    push(f + 14, vec(0, 0, 1, 0, 0, 0, exp_lost), "recover_ready");
    to_cyc(f + 1);
    soft_reset = 1'b0;
    to_cyc(f + 16);

    lose_base();
    d = cyc;
    locked = 1'b1;
    to_cyc(d + 5);
    rst_n = 1'b0;
    exp_lost = 0;
    push(d + 5, vec(1, 1, 0, 0, 0, 0, 0), "async_reset");
    to_cyc(d + 7);
    rst_n = 1'b1;
    r = cyc;
    push(r + 4, vec(0, 1, 0, 0, 0, 0, 0), "restart_pllrst");
    push(r + 13, vec(0, 0, 1, 0, 0, 0, 0), "restart_ready");
    to_cyc(r + 20);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL %s missing got=none want cyc=%0d vec=%h",
               e.tag, e.cyc, e.v);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
